// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder.
// Optional macro NIBBLE_SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  logic                   start;
  logic                   sub;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   cin;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   sum;
  logic                   cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic                   ovf;

  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Digit-serial wide adder/subtractor driving an external combinational 4-bit adder stage.
// One nibble per cycle, carry chained through a register.
// Optional macro NIBBLE_SERIAL_ADDER_OVF_EN adds the held signed-overflow flag ovf.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  nibble_serial_adder_if.slave    bus,
  output logic [3:0]              add_x,
  output logic [3:0]              add_y,
  output logic                    add_cin,
  input  logic [3:0]              add_s,
  input  logic                    add_cout
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [NIBBLES-1:0][3:0]  opa_q, opa_d;
  logic [NIBBLES-1:0][3:0]  opb_q, opb_d;
  logic [NIBBLES-1:0][3:0]  sum_q, sum_d;
  logic                     carry_q, carry_d;
  logic                     cout_q, cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic                     ovf_q, ovf_d;
`endif

  // Next-state, datapath update and adder-stage drive.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    add_x   = 4'h0;
    add_y   = 4'h0;
    add_cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1; result registers keep the previous value.
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        add_x        = opa_q[idx_q];
        add_y        = opb_q[idx_q];
        add_cin      = carry_q;
        sum_d[idx_q] = add_s;
        carry_d      = add_cout;
        idx_d        = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          cout_d  = add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = (opa_q[idx_q][3] == opb_q[idx_q][3]) && (add_s[3] != opa_q[idx_q][3]);
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) with a behavioural adder stage.
// Overflow checks are compiled in when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] add_x, add_y, add_s;
  logic       add_cin, add_cout;
  int         total = 0;
  int         bad = 0;

  nibble_serial_adder_if #(.NIBBLES(N)) bus ();

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Existing 4-bit ripple-carry adder stage, modelled behaviourally.
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from #1 after a rising edge; optionally pulses a second start mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic ci, input bit intrude);
    logic [W:0]   full;
    logic [W-1:0] yv;
    longint       sa, sb, r;
    logic         ov;
    if (s) begin
      full[W-1:0] = a - b;
      full[W]     = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = s ? (sa - sb) : (sa + sb + longint'(ci));
    ov = (r > 64'sd32767) || (r < -64'sd32768);
    yv = s ? ~b : b;

    bus.a = a; bus.b = b; bus.sub = s; bus.cin = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the DUT must work from latched operands.
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.sub = ~s; bus.cin = ~ci;
    for (int c = 0; c < N; c++) begin
      check("busy_run", bus.busy, 1);
      check("done_run", bus.done, 0);
      check("add_x", add_x, (a >> (4 * c)) & 'hF);
      check("add_y", add_y, (yv >> (4 * c)) & 'hF);
      if (c == 0) check("add_cin", add_cin, s ? 1'b1 : ci);
      if (intrude && c == 1) begin
        bus.a = 16'hAAAA;
        bus.start = 1'b1;
      end
      if (intrude && c == 2) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    check("done_pulse", bus.done, 1);
    check("busy_done", bus.busy, 0);
    check("sum", bus.sum, full[W-1:0]);
    check("cout", bus.cout, full[W]);
    check("add_x_idle", add_x, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("ovf", bus.ovf, ov);
`endif
    @(posedge clk); #1;
    check("done_low", bus.done, 0);
    check("busy_low", bus.busy, 0);
    check("sum_held", bus.sum, full[W-1:0]);
    check("cout_held", bus.cout, full[W]);
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_add", {add_x, add_y, add_cin}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic add
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check("basic_sum", bus.sum, 16'h5555);
    // Carry chain
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("chain_sum", bus.sum, 16'h0000);
    check("chain_cout", bus.cout, 1);
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("chain_cin_cout", bus.cout, 1);
    // Signed overflow cases
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("ovf_add_sum", bus.sum, 16'h8000);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("ovf_add_flag", bus.ovf, 1);
`endif
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("ovf_sub_sum", bus.sum, 16'h7FFF);
    // Subtract
    run_op(16'h1000, 16'h0001, 1'b1, 1'b1, 1'b0);
    check("sub_sum", bus.sum, 16'h0FFF);
    check("sub_cout", bus.cout, 1);
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("borrow_cout", bus.cout, 0);
    // Start while busy
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("intrude_sum", bus.sum, 16'h0002);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Reset mid-operation at idx=2
    bus.a = 16'h5678; bus.b = 16'h1111; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", bus.busy, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_cout", bus.cout, 0);
    check("mid_rst_add", {add_x, add_y, add_cin}, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("mid_rst_ovf", bus.ovf, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", bus.done, 0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", bus.busy, 0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    check("post_rst_sum", bus.sum, 16'h0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
